cpu_multicycle: RTL and testbench

CPU_MULTICYCLE -- requirements
Module: cpu_multicycle

---
 rtl/cpu_pkg.sv | 24 ++
 rtl/regfile_param.sv | 23 ++
 rtl/cpu_multicycle.sv | 120 ++++++++++++
 tb/tb_cpu_multicycle.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: opcodes, FSM state encoding and instruction field positions
package cpu_pkg;
  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_MOV  = 4'h6;
  localparam logic [3:0] OP_LDI  = 4'h7;
  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_BEQZ = 4'h9;
  localparam logic [3:0] OP_BNEZ = 4'hA;
  localparam logic [3:0] OP_HALT = 4'hF;
  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_WB     = 3'd3;
  localparam logic [2:0] S_HALT   = 3'd4;
  localparam int OP_LSB  = 12;
  localparam int RD_LSB  = 8;
  localparam int RS_LSB  = 4;
  localparam int IMM_LSB = 0;
endpackage

// File: rtl/regfile_param.sv
// regfile_param: 2-read 1-write register file with register 0 fixed at zero
module regfile_param #(
  parameter int DATA_W = 8,
  parameter int REG_AW = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [REG_AW-1:0] raddr_a,
  input  logic [REG_AW-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b
);
  logic [DATA_W-1:0] r_regs [0:2**REG_AW-1];
  always_ff @(posedge clk) begin
    if (rst) r_regs <= '{default: '0};
    else if (we && waddr != '0) r_regs[waddr] <= wdata;
  end
  assign rdata_a = raddr_a == '0 ? '0 : r_regs[raddr_a];
  assign rdata_b = raddr_b == '0 ? '0 : r_regs[raddr_b];
endmodule

// File: rtl/cpu_multicycle.sv
// cpu_multicycle: FETCH/DECODE/EXEC/WB multicycle CPU with sticky halt and illegal status
module cpu_multicycle
  import cpu_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int REG_AW = 3,
  parameter int PC_W   = 8
) (
  input  logic              CLK,
  input  logic              RST,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_ack,
  input  logic [15:0]       imem_data,
  output logic [PC_W-1:0]   pc,
  output logic              wb_en,
  output logic [REG_AW-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic              retire,
  output logic              zero_flag,
  output logic              carry_flag,
  output logic              halted,
  output logic              illegal
);
  logic [2:0]        r_state;
  logic [15:0]       r_ir;
  logic [PC_W-1:0]   r_pc;
  logic [DATA_W-1:0] r_a, r_b, r_res;
  logic              r_cy, r_take, r_zero, r_carry, r_halted, r_illegal;
  logic [DATA_W-1:0] w_rd_val, w_rs_val, w_imm_d;
  logic [PC_W-1:0]   w_imm_p, w_npc;
  logic [3:0]        w_op;
  logic [REG_AW-1:0] w_rd, w_rs;
  logic [DATA_W:0]   w_sum, w_dif, w_alu;
  logic              w_alu_op, w_legal, w_take, w_unused_ir;
  assign w_op        = r_ir[OP_LSB +: 4];
  assign w_rd        = r_ir[RD_LSB +: REG_AW];
  assign w_rs        = r_ir[RS_LSB +: REG_AW];
  assign w_imm_d     = DATA_W'(r_ir[IMM_LSB +: 8]);
  assign w_imm_p     = PC_W'(r_ir[IMM_LSB +: 8]);
  assign w_unused_ir = ^r_ir[11:4];
  assign w_alu_op    = w_op >= OP_ADD && w_op <= OP_LDI;
  assign w_legal     = w_op <= OP_BNEZ || w_op == OP_HALT;
  assign w_sum       = {1'b0, r_a} + {1'b0, r_b};
  assign w_dif       = {1'b0, r_a} - {1'b0, r_b};
  always_comb begin
    w_alu  = w_op == OP_ADD ? w_sum :
             w_op == OP_SUB ? w_dif :
             {1'b0, w_op == OP_AND ? r_a & r_b :
                    w_op == OP_OR  ? r_a | r_b :
                    w_op == OP_XOR ? r_a ^ r_b :
                    w_op == OP_MOV ? r_b : w_imm_d};
    w_take = w_op == OP_JMP || (w_op == OP_BEQZ && r_a == '0) || (w_op == OP_BNEZ && r_a != '0);
    w_npc  = r_take ? w_imm_p : r_pc + PC_W'(1);
  end
  regfile_param #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_rf (
    .clk(CLK), .rst(RST), .we(wb_en), .waddr(w_rd), .wdata(r_res),
    .raddr_a(w_rd), .raddr_b(w_rs), .rdata_a(w_rd_val), .rdata_b(w_rs_val)
  );
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= S_FETCH;
      r_ir      <= '0;
      r_pc      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_res     <= '0;
      r_cy      <= 1'b0;
      r_take    <= 1'b0;
      r_zero    <= 1'b0;
      r_carry   <= 1'b0;
      r_halted  <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH: if (imem_ack) begin
          r_ir    <= imem_data;
          r_state <= S_DECODE;
        end
        S_DECODE: begin
          r_a     <= w_rd_val;
          r_b     <= w_rs_val;
          r_state <= S_EXEC;
        end
        S_EXEC: begin
          {r_cy, r_res} <= w_alu;
          r_take        <= w_take;
          r_state       <= S_WB;
        end
        S_WB: begin
          if (w_alu_op) begin
            r_zero  <= r_res == '0;
            r_carry <= r_cy;
          end
          if (!w_legal) r_illegal <= 1'b1;
          if (w_op == OP_HALT) begin
            r_halted <= 1'b1;
            r_state  <= S_HALT;
          end else begin
            r_pc    <= w_npc;
            r_state <= S_FETCH;
          end
        end
        S_HALT: r_state <= S_HALT;
        default: r_state <= S_FETCH;
      endcase
    end
  end
  assign imem_req   = r_state == S_FETCH && !RST;
  assign imem_addr  = r_pc;
  assign pc         = r_pc;
  assign retire     = r_state == S_WB && !RST;
  assign wb_en      = retire && w_alu_op;
  assign wb_addr    = w_rd;
  assign wb_data    = r_res;
  assign zero_flag  = r_zero;
  assign carry_flag = r_carry;
  assign halted     = r_halted;
  assign illegal    = r_illegal;
endmodule

// File: tb/tb_cpu_multicycle.sv
// tb_cpu_multicycle: scoreboard bench driving directed programs through an instruction memory model
module tb_cpu_multicycle;
  logic        CLK = 0, RST = 1, imem_ack = 0;
  logic [15:0] imem_data = '0;
  logic        imem_req, wb_en, retire, zero_flag, carry_flag, halted, illegal;
  logic [7:0]  imem_addr, pc, wb_data;
  logic [2:0]  wb_addr;
  typedef struct {
    bit en; int a; int d; bit z; bit c; bit il; bit hl; int npc; int cyc;
  } exp_t;
  exp_t        q[$];
  logic [15:0] mem [0:255];
  int          checks = 0, errors = 0, ack_delay = 0, cnt = 0, cyc = 0;
  cpu_multicycle #(.DATA_W(8), .REG_AW(3), .PC_W(8)) dut (
    .CLK(CLK), .RST(RST), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_data(imem_data), .pc(pc), .wb_en(wb_en),
    .wb_addr(wb_addr), .wb_data(wb_data), .retire(retire), .zero_flag(zero_flag),
    .carry_flag(carry_flag), .halted(halted), .illegal(illegal)
  );
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= RST ? 0 : cyc + 1;
  always @(posedge CLK) begin
    #2;
    if (imem_req) begin
      if (cnt >= ack_delay) begin
        imem_ack  = 1;
        imem_data = mem[imem_addr];
      end else begin
        imem_ack = 0;
        cnt++;
      end
    end else begin
      imem_ack = 0;
      cnt      = 0;
    end
  end
  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask
  task automatic ex(bit en, int a, int d, bit z, bit c, bit il, bit hl, int npc, int cy);
    exp_t e;
    e = '{en, a, d, z, c, il, hl, npc, cy};
    q.push_back(e);
  endtask
  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 16'hF000;
  endtask
  task automatic do_reset(int n);
    RST = 1;
    repeat (n) @(posedge CLK);
    #1;
    chk("reset_state", 32'({imem_req, wb_en, retire, zero_flag, carry_flag, halted, illegal, pc}), 0);
    RST = 0;
  endtask
  task automatic run(int max_cyc);
    for (int i = 0; i < max_cyc && !halted; i++) @(negedge CLK);
    chk("halt_reached", 32'(halted), 1);
    repeat (2) @(negedge CLK);
    chk("queue_drained", 32'(q.size()), 0);
  endtask
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (retire) begin
        if (q.size() == 0) chk("unexpected_retire", 32'({wb_en, wb_addr, wb_data}), 0);
        else begin
          e = q.pop_front();
          chk("wb_en", 32'(wb_en), 32'(e.en));
          if (e.en) chk("wb_dst", 32'({wb_addr, wb_data}), 32'({e.a[2:0], e.d[7:0]}));
          if (e.cyc >= 0) chk("retire_cyc", 32'(cyc), 32'(e.cyc));
          @(negedge CLK);
          chk("flags", 32'({zero_flag, carry_flag, illegal, halted}), 32'({e.z, e.c, e.il, e.hl}));
          chk("next_pc", 32'(pc), 32'(e.npc));
          chk("imem_addr", 32'(imem_addr), 32'(e.npc));
        end
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
  initial begin
    int bad;
    clear_mem();
    mem[0] = 16'h7105; mem[1] = 16'h7203; mem[2] = 16'h1120;
    ex(1, 1, 5, 0, 0, 0, 0, 1, 3);
    ex(1, 2, 3, 0, 0, 0, 0, 2, 7);
    ex(1, 1, 8, 0, 0, 0, 0, 3, 11);
    ex(0, 0, 0, 0, 0, 0, 1, 3, 15);
    do_reset(2);
    run(100);
    clear_mem();
    mem[0] = 16'h71FF; mem[1] = 16'h7201; mem[2] = 16'h1120; mem[3] = 16'h2210; mem[4] = 16'h2120;
    ex(1, 1, 8'hFF, 0, 0, 0, 0, 1, -1);
    ex(1, 2, 1, 0, 0, 0, 0, 2, -1);
    ex(1, 1, 0, 1, 1, 0, 0, 3, -1);
    ex(1, 2, 1, 0, 0, 0, 0, 4, -1);
    ex(1, 1, 8'hFF, 0, 1, 0, 0, 5, -1);
    ex(0, 0, 0, 0, 1, 0, 1, 5, -1);
    do_reset(2);
    run(100);
    clear_mem();
    mem[0] = 16'hA205; mem[1] = 16'h7100; mem[2] = 16'h9110;
    mem[8'h10] = 16'hA120; mem[8'h11] = 16'h7201; mem[8'h12] = 16'h80FF; mem[8'hFF] = 16'h0000;
    ex(0, 0, 0, 0, 0, 0, 0, 1, -1);
    ex(1, 1, 0, 1, 0, 0, 0, 2, -1);
    ex(0, 0, 0, 1, 0, 0, 0, 8'h10, -1);
    ex(0, 0, 0, 1, 0, 0, 0, 8'h11, -1);
    ex(1, 2, 1, 0, 0, 0, 0, 8'h12, -1);
    ex(0, 0, 0, 0, 0, 0, 0, 8'hFF, -1);
    ex(0, 0, 0, 0, 0, 0, 0, 0, -1);
    ex(0, 0, 0, 0, 0, 0, 0, 5, -1);
    ex(0, 0, 0, 0, 0, 0, 1, 5, -1);
    do_reset(2);
    run(200);
    clear_mem();
    mem[0] = 16'h7007; mem[1] = 16'h6300;
    ex(1, 0, 7, 0, 0, 0, 0, 1, 6);
    ex(1, 3, 0, 1, 0, 0, 0, 2, -1);
    ex(0, 0, 0, 1, 0, 0, 1, 2, -1);
    ack_delay = 3;
    do_reset(2);
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      if (!imem_req || imem_addr != 0 || retire) bad++;
    end
    chk("fetch_hold", 32'(bad), 0);
    @(negedge CLK);
    chk("fetch_done", 32'(imem_req), 0);
    run(200);
    ack_delay = 0;
    clear_mem();
    mem[0] = 16'hB123; mem[1] = 16'h0000; mem[2] = 16'h0000; mem[3] = 16'h7400;
    ex(0, 0, 0, 0, 0, 1, 0, 1, -1);
    ex(0, 0, 0, 0, 0, 1, 0, 2, -1);
    ex(0, 0, 0, 0, 0, 1, 0, 3, -1);
    ex(1, 4, 0, 1, 0, 1, 0, 4, -1);
    ex(0, 0, 0, 1, 0, 1, 1, 4, -1);
    do_reset(2);
    run(100);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (imem_req || wb_en || retire || pc != 4) bad++;
    end
    chk("halt_quiet", 32'(bad), 0);
    chk("sticky_status", 32'({halted, illegal}), 32'b11);
    clear_mem();
    mem[0] = 16'h7109; mem[1] = 16'h7206; mem[2] = 16'h1120;
    ex(1, 1, 9, 0, 0, 0, 0, 1, 3);
    ex(1, 2, 6, 0, 0, 0, 0, 2, 7);
    do_reset(2);
    for (int i = 0; i < 50 && cyc != 10; i++) @(negedge CLK);
    chk("reach_exec", 32'(cyc), 10);
    chk("pre_abort_drain", 32'(q.size()), 0);
    clear_mem();
    mem[0] = 16'h6310; mem[1] = 16'h6320;
    ex(1, 3, 0, 1, 0, 0, 0, 1, 3);
    ex(1, 3, 0, 1, 0, 0, 0, 2, -1);
    ex(0, 0, 0, 1, 0, 0, 1, 2, -1);
    do_reset(1);
    #1;
    chk("refetch_addr0", 32'({imem_req, imem_addr}), 32'({1'b1, 8'h00}));
    run(100);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
